// File: rtl/appmul_recovery_ctrl.sv
// Sequencer for a shared approximate multiplier core: issues operands, captures the
// approximate product and error vector, and optionally recovers the exact sum serially.
module appmul_recovery_ctrl #(
  parameter int unsigned W        = 16,
  parameter int unsigned CORE_LAT = 1,
  parameter int unsigned SEG_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic              in_mode,
  output logic [W-1:0]      core_a,
  output logic [W-1:0]      core_b,
  input  logic [2*W-1:0]    core_prod,
  input  logic [2*W-1:0]    core_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    out_prod,
  output logic              out_mode,
  output logic              out_err_nz,
  output logic [15:0]       rec_count
);

  localparam int unsigned PW     = 2 * W;
  localparam int unsigned NSEG   = PW / SEG_W;
  localparam int unsigned SEG_IW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [2:0]        LAT      = 3'(CORE_LAT);
  localparam logic [SEG_IW-1:0] SEG_LAST = SEG_IW'(NSEG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        wait_cnt;
  logic [SEG_IW-1:0] seg_cnt;
  logic              mode_q;
  logic              carry_q;
  logic [PW-1:0]     err_q;

  logic              accept;
  logic              capture;
  logic              seg_last;
  logic              handshake;
  logic [SEG_W:0]    slice_sum;
  logic [PW-1:0]     prod_rot;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d   = state_q;
    accept    = in_valid & in_ready;
    capture   = (state_q == S_WAIT) && (wait_cnt == 3'd0);
    seg_last  = (seg_cnt == SEG_LAST);
    handshake = out_valid & out_ready;
    slice_sum = {1'b0, out_prod[SEG_W-1:0]} + {1'b0, err_q[SEG_W-1:0]}
              + (SEG_W+1)'(carry_q);
    // Work register rotates right by one slice per step, so after NSEG steps
    // every slice is back in its original position.
    prod_rot  = PW'({slice_sum[SEG_W-1:0], out_prod} >> SEG_W);

    case (state_q)
      S_IDLE:    if (accept) state_d = S_WAIT;
      S_WAIT:    if (capture) state_d = mode_q ? S_RECOVER : S_DONE;
      S_RECOVER: if (seg_last) state_d = S_DONE;
      S_DONE:    if (handshake) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath, counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      out_prod   <= '0;
      out_mode   <= 1'b0;
      out_err_nz <= 1'b0;
      rec_count  <= '0;
      wait_cnt   <= '0;
      seg_cnt    <= '0;
      mode_q     <= 1'b0;
      carry_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_DONE);

      if (accept) begin
        core_a   <= in_a;
        core_b   <= in_b;
        mode_q   <= in_mode;
        wait_cnt <= LAT;
      end

      if ((state_q == S_WAIT) && !capture) wait_cnt <= wait_cnt - 3'd1;

      if (capture) begin
        out_prod   <= core_prod;
        err_q      <= core_err;
        out_err_nz <= |core_err;
        out_mode   <= mode_q;
        carry_q    <= 1'b0;
        seg_cnt    <= '0;
      end

      if (state_q == S_RECOVER) begin
        out_prod <= prod_rot;
        err_q    <= err_q >> SEG_W;
        carry_q  <= slice_sum[SEG_W];
        seg_cnt  <= seg_cnt + SEG_IW'(1);
      end

      if (handshake && out_mode && (rec_count != 16'hFFFF))
        rec_count <= rec_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_appmul_recovery_ctrl.sv
// Directed self-checking bench for appmul_recovery_ctrl with a programmable stub core
// (W=16, CORE_LAT=1, SEG_W=8).
module tb_appmul_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        in_mode;
  logic [15:0] core_a, core_b;
  logic [31:0] core_prod, core_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;
  logic        out_mode;
  logic        out_err_nz;
  logic [15:0] rec_count;

  int errors = 0;
  int checks = 0;
  int lat;

  appmul_recovery_ctrl #(.W(16), .CORE_LAT(1), .SEG_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .core_a(core_a), .core_b(core_b),
    .core_prod(core_prod), .core_err(core_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_mode(out_mode),
    .out_err_nz(out_err_nz), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then count cycles until out_valid (bounded).
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [31:0] p, input logic [31:0] e);
    in_a = a; in_b = b; in_mode = m; core_prod = p; core_err = e;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step(1);
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
    core_prod = '0; core_err = '0; out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rec_count", 32'(rec_count), 32'd0);
    check("rst_out_prod", out_prod, 32'd0);
    check("rst_core_a", 32'(core_a), 32'd0);

    // Approximate result, error vector nonzero.
    issue(16'd3, 16'd5, 1'b0, 32'd13, 32'd2);
    check("m0_latency", 32'(lat), 32'd2);
    check("m0_core_a", 32'(core_a), 32'd3);
    check("m0_core_b", 32'(core_b), 32'd5);
    check("m0_out_prod", out_prod, 32'd13);
    check("m0_err_nz", 32'(out_err_nz), 32'd1);
    check("m0_out_mode", 32'(out_mode), 32'd0);
    check("m0_in_ready_busy", 32'(in_ready), 32'd0);
    handshake();
    check("m0_valid_drop", 32'(out_valid), 32'd0);
    check("m0_rec_count", 32'(rec_count), 32'd0);
    check("m0_prod_hold", out_prod, 32'd13);
    check("m0_in_ready_back", 32'(in_ready), 32'd1);

    // Recovered result: 13 + 2.
    issue(16'd3, 16'd5, 1'b1, 32'd13, 32'd2);
    check("m1_latency", 32'(lat), 32'd6);
    check("m1_out_prod", out_prod, 32'd15);
    check("m1_out_mode", 32'(out_mode), 32'd1);
    check("m1_rec_before", 32'(rec_count), 32'd0);
    handshake();
    check("m1_rec_count", 32'(rec_count), 32'd1);

    // Carry crossing a slice boundary.
    issue(16'd1, 16'd1, 1'b1, 32'h0000_00FF, 32'h0000_0001);
    check("carry_latency", 32'(lat), 32'd6);
    check("carry_out_prod", out_prod, 32'h0000_0100);
    handshake();
    check("carry_rec_count", 32'(rec_count), 32'd2);

    // Carry out of the top slice is discarded.
    issue(16'd2, 16'd2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    check("wrap_out_prod", out_prod, 32'h0000_0000);
    check("wrap_err_nz", 32'(out_err_nz), 32'd1);
    handshake();
    check("wrap_rec_count", 32'(rec_count), 32'd3);

    // Backpressure in DONE; in_valid pulses there are ignored.
    issue(16'd7, 16'd9, 1'b0, 32'h1234_5678, 32'h0000_0000);
    check("bp_out_prod0", out_prod, 32'h1234_5678);
    check("bp_err_nz", 32'(out_err_nz), 32'd0);
    for (int i = 0; i < 5; i++) begin
      in_a = 16'hAAAA; in_b = 16'h5555; in_valid = (i % 2 == 0);
      step(1);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_prod", out_prod, 32'h1234_5678);
      check("bp_core_a", 32'(core_a), 32'd7);
    end
    in_valid = 1'b0;
    handshake();
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_rec_count", 32'(rec_count), 32'd3);

    // Accept on the cycle right after the handshake, then reset in recover slice 2.
    in_a = 16'h0011; in_b = 16'h0022; in_mode = 1'b1;
    core_prod = 32'h0101_0101; core_err = 32'h0202_0202;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("resume_core_a", 32'(core_a), 32'h0011);
    check("resume_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step(4);
    check("abort_pre_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_core_a", 32'(core_a), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    check("abort_rec_count", 32'(rec_count), 32'd0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
